// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM states, owner codes and
// the data word returned to a requester when its memory access times out.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto a single memory channel, one
// transaction in flight, LSU priority, with a response timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_reqValid,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_respValid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_reqValid,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_respValid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_reqValid,
    input  logic                mem_reqReady,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_respValid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_err,
    output logic [1:0]          dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_RDATA);

    // Request channel: a transfer happens on every rising edge where
    // mem_reqValid && mem_reqReady; once raised, mem_reqValid and all mem_*
    // fields hold steady until that edge. Responses need no ready.

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               owner_q;
    logic               grant_ifu, grant_lsu, handshake, resp_hit, timed_out;
    logic [DATA_W-1:0]  resp_word;

    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        handshake = 1'b0;
        resp_hit  = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_reqValid) begin
                    grant_lsu = 1'b1;
                    state_d   = REQ;
                end else if (ifu_reqValid) begin
                    grant_ifu = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (mem_reqValid && mem_reqReady) begin
                    handshake = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // cnt_q counts completed empty WAIT cycles; this one is the TIMEOUT-th
                if (mem_respValid) begin
                    resp_hit = 1'b1;
                    state_d  = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        resp_word = resp_hit ? mem_rdata : ERR_WORD;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            owner_q       <= OWNER_IFU;
            mem_reqValid  <= 1'b0;
            mem_wen       <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            ifu_respValid <= 1'b0;
            lsu_respValid <= 1'b0;
            ifu_rdata     <= '0;
            lsu_rdata     <= '0;
            bus_err       <= 1'b0;
        end else begin
            ifu_respValid <= 1'b0;
            lsu_respValid <= 1'b0;
            bus_err       <= timed_out;

            if (grant_lsu) begin
                owner_q      <= OWNER_LSU;
                mem_addr     <= lsu_addr;
                mem_wen      <= lsu_wen;
                mem_wdata    <= lsu_wdata;
                mem_wmask    <= lsu_wmask;
                mem_reqValid <= 1'b1;
            end else if (grant_ifu) begin
                owner_q      <= OWNER_IFU;
                mem_addr     <= ifu_addr;
                mem_wen      <= 1'b0;
                mem_wdata    <= '0;
                mem_wmask    <= '0;
                mem_reqValid <= 1'b1;
            end

            if (handshake) begin
                mem_reqValid <= 1'b0;
                cnt_q        <= '0;
            end else if (state_q == WAIT && !mem_respValid) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (resp_hit || timed_out) begin
                if (owner_q == OWNER_LSU) begin
                    lsu_rdata     <= resp_word;
                    lsu_respValid <= 1'b1;
                end else begin
                    ifu_rdata     <= resp_word;
                    ifu_respValid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected memory requests and responses
// are queued by the stimulus and popped by a negedge monitor.
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;
    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              ifu_reqValid = 1'b0;
    logic [31:0]       ifu_addr = '0;
    logic              ifu_respValid;
    logic [31:0]       ifu_rdata;
    logic              lsu_reqValid = 1'b0;
    logic              lsu_wen = 1'b0;
    logic [31:0]       lsu_addr = '0;
    logic [31:0]       lsu_wdata = '0;
    logic [3:0]        lsu_wmask = '0;
    logic              lsu_respValid;
    logic [31:0]       lsu_rdata;
    logic              mem_reqValid;
    logic              mem_reqReady = 1'b0;
    logic              mem_wen;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_respValid = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic              bus_err;
    logic [1:0]        dbg_state;

    int checks = 0;
    int failures = 0;

    // {is_lsu, err, data}
    logic [33:0] exp_q[$];
    // {addr, wen, wdata, wmask}
    logic [68:0] memx_q[$];
    logic [33:0] mon_e;
    logic [68:0] mon_m;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
        .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
        .lsu_reqValid(lsu_reqValid), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
        .mem_reqValid(mem_reqValid), .mem_reqReady(mem_reqReady), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_respValid(mem_respValid), .mem_rdata(mem_rdata),
        .bus_err(bus_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_mem(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
        memx_q.push_back({a, w, d, m});
    endtask

    task automatic push_resp(input logic is_lsu, input logic err, input logic [31:0] d);
        exp_q.push_back({is_lsu, err, d});
    endtask

    // Returns just after the handshake edge (DUT now in WAIT).
    task automatic wait_hs(input string tag);
        int n = 0;
        while (!(mem_reqValid && mem_reqReady) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check({tag, "_handshake_timeout"}, 64'd0, 64'd1);
        else tick();
    endtask

    // Called in a WAIT cycle; returns just after the edge into RESP.
    task automatic mem_reply(input logic [31:0] d);
        mem_respValid = 1'b1;
        mem_rdata     = d;
        tick();
        mem_respValid = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_reqValid && mem_reqReady) begin
                if (memx_q.size() == 0) begin
                    check("unexpected_mem_req", 64'd1, 64'd0);
                end else begin
                    mon_m = memx_q.pop_front();
                    check("mem_addr",  64'(mem_addr),  64'(mon_m[68:37]));
                    check("mem_wen",   64'(mem_wen),   64'(mon_m[36]));
                    check("mem_wdata", 64'(mem_wdata), 64'(mon_m[35:4]));
                    check("mem_wmask", 64'(mem_wmask), 64'(mon_m[3:0]));
                end
            end
            if (ifu_respValid || lsu_respValid || bus_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_port", 64'({ifu_respValid, lsu_respValid}),
                          mon_e[33] ? 64'd1 : 64'd2);
                    check("resp_data", 64'(mon_e[33] ? lsu_rdata : ifu_rdata), 64'(mon_e[31:0]));
                    check("resp_bus_err", 64'(bus_err), 64'(mon_e[32]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #2 reset = 1'b1;
        tick();
        tick();
        check("rst_state",       64'(dbg_state),     64'(S_IDLE));
        check("rst_mem_reqValid",64'(mem_reqValid),  64'd0);
        check("rst_ifu_resp",    64'(ifu_respValid), 64'd0);
        check("rst_lsu_resp",    64'(lsu_respValid), 64'd0);
        check("rst_bus_err",     64'(bus_err),       64'd0);
        check("rst_ifu_rdata",   64'(ifu_rdata),     64'd0);
        check("rst_lsu_rdata",   64'(lsu_rdata),     64'd0);
        check("rst_mem_fields",  64'({mem_addr, mem_wen, mem_wmask}), 64'd0);
        check("rst_mem_wdata",   64'(mem_wdata),     64'd0);
        reset = 1'b0;
        tick();

        // Single fetch, best-case latency
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_0000;
        mem_reqReady = 1'b1;
        push_mem(32'h8000_0000, 1'b0, 32'h0, 4'h0);
        push_resp(1'b0, 1'b0, 32'h0010_0073);
        tick();
        check("t1_req_state", 64'(dbg_state), 64'(S_REQ));
        tick();
        check("t1_wait_state", 64'(dbg_state), 64'(S_WAIT));
        check("t1_no_early_resp", 64'(ifu_respValid), 64'd0);
        mem_reply(32'h0010_0073);
        check("t1_latency3_resp", 64'(ifu_respValid), 64'd1);
        check("t1_lsu_quiet", 64'(lsu_respValid), 64'd0);
        ifu_reqValid = 1'b0;
        tick();
        check("t1_back_idle", 64'(dbg_state), 64'(S_IDLE));
        check("t1_resp_one_cycle", 64'(ifu_respValid), 64'd0);
        check("t1_rdata_hold", 64'(ifu_rdata), 64'h0010_0073);

        // Simultaneous requests: LSU first, IFU only from the next IDLE
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_0004;
        lsu_reqValid = 1'b1;
        lsu_wen      = 1'b0;
        lsu_addr     = 32'h0000_0100;
        push_mem(32'h0000_0100, 1'b0, 32'h0, 4'h0);
        push_resp(1'b1, 1'b0, 32'hCAFE_0001);
        push_mem(32'h8000_0004, 1'b0, 32'h0, 4'h0);
        push_resp(1'b0, 1'b0, 32'h0000_0013);
        tick();
        check("t2_lsu_addr_first", 64'(mem_addr), 64'h100);
        wait_hs("t2_lsu");
        mem_reply(32'hCAFE_0001);
        lsu_reqValid = 1'b0;
        tick();
        check("t2_no_grant_in_resp", 64'(dbg_state), 64'(S_IDLE));
        check("t2_no_req_in_idle", 64'(mem_reqValid), 64'd0);
        tick();
        wait_hs("t2_ifu");
        mem_reply(32'h0000_0013);
        ifu_reqValid = 1'b0;
        tick();

        // Backpressure on a store; requester drops reqValid after grant
        lsu_reqValid = 1'b1;
        lsu_wen      = 1'b1;
        lsu_addr     = 32'h0000_0200;
        lsu_wdata    = 32'hA5A5_A5A5;
        lsu_wmask    = 4'h3;
        mem_reqReady = 1'b0;
        push_mem(32'h0000_0200, 1'b1, 32'hA5A5_A5A5, 4'h3);
        push_resp(1'b1, 1'b0, 32'h5A5A_0000);
        tick();
        lsu_reqValid = 1'b0;
        lsu_wen      = 1'b0;
        lsu_addr     = 32'h0;
        lsu_wdata    = 32'h0;
        lsu_wmask    = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check("t3_bp_valid", 64'(mem_reqValid), 64'd1);
            check("t3_bp_addr",  64'(mem_addr),     64'h200);
            check("t3_bp_wdata", 64'(mem_wdata),    64'hA5A5_A5A5);
            check("t3_bp_wmask", 64'(mem_wmask),    64'h3);
            check("t3_bp_wen",   64'(mem_wen),      64'd1);
            tick();
        end
        mem_reqReady = 1'b1;
        wait_hs("t3");
        check("t3_single_hs", 64'(mem_reqValid), 64'd0);
        mem_reply(32'h5A5A_0000);
        tick();

        // Timeout after TIMEOUT empty WAIT cycles
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_0008;
        push_mem(32'h8000_0008, 1'b0, 32'h0, 4'h0);
        push_resp(1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        wait_hs("t4");
        repeat (TIMEOUT - 1) tick();
        check("t4_still_wait", 64'(dbg_state), 64'(S_WAIT));
        check("t4_no_early_err", 64'(bus_err), 64'd0);
        tick();
        check("t4_bus_err", 64'(bus_err), 64'd1);
        check("t4_ifu_resp", 64'(ifu_respValid), 64'd1);
        check("t4_err_data", 64'(ifu_rdata), 64'hDEAD_BEEF);
        ifu_reqValid = 1'b0;
        tick();
        check("t4_err_one_cycle", 64'(bus_err), 64'd0);

        // Reset during WAIT, late response ignored
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_000C;
        push_mem(32'h8000_000C, 1'b0, 32'h0, 4'h0);
        tick();
        wait_hs("t5_abandon");
        tick();
        reset        = 1'b1;
        ifu_reqValid = 1'b0;
        #1;
        check("t5_async_state", 64'(dbg_state), 64'(S_IDLE));
        check("t5_async_reqvalid", 64'(mem_reqValid), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        mem_respValid = 1'b1;
        mem_rdata     = 32'hBAD0_BAD0;
        tick();
        mem_respValid = 1'b0;
        check("t5_late_state", 64'(dbg_state), 64'(S_IDLE));
        check("t5_late_ifu_rdata", 64'(ifu_rdata), 64'd0);
        check("t5_late_no_resp", 64'({ifu_respValid, lsu_respValid}), 64'd0);
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_0010;
        push_mem(32'h8000_0010, 1'b0, 32'h0, 4'h0);
        push_resp(1'b0, 1'b0, 32'h0000_0093);
        tick();
        wait_hs("t5_next");
        mem_reply(32'h0000_0093);
        check("t5_next_resp", 64'(ifu_respValid), 64'd1);
        ifu_reqValid = 1'b0;
        tick();

        // Spurious response in IDLE
        mem_respValid = 1'b1;
        mem_rdata     = 32'h0000_1234;
        tick();
        mem_respValid = 1'b0;
        check("t6_state", 64'(dbg_state), 64'(S_IDLE));
        check("t6_ifu_rdata", 64'(ifu_rdata), 64'h93);
        check("t6_lsu_rdata", 64'(lsu_rdata), 64'h0);
        check("t6_no_pulse", 64'({ifu_respValid, lsu_respValid, bus_err}), 64'd0);
        tick();
        tick();

        check("drain_resp_q", 64'(exp_q.size()), 64'd0);
        check("drain_mem_q", 64'(memx_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of all address buses.
REQ-002 SHALL have parameter DATA_W, default 32, width of all data buses; write mask width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, number of WAIT cycles without mem_respValid before an error response.
REQ-004 SHALL have port clock, input, 1, system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ifu_reqValid, input, 1, fetch request, held high until its response.
REQ-007 SHALL have port ifu_addr, input, ADDR_W, fetch address.
REQ-008 SHALL have port ifu_respValid, output, 1, one-cycle fetch response pulse.
REQ-009 SHALL have port ifu_rdata, output, DATA_W, fetch data, held until the next IFU response.
REQ-010 SHALL have ports lsu_reqValid (in, 1), lsu_wen (in, 1), lsu_addr (in, ADDR_W), lsu_wdata (in, DATA_W), lsu_wmask (in, DATA_W/8): load/store request, held until response.
REQ-011 SHALL have ports lsu_respValid (out, 1) and lsu_rdata (out, DATA_W), with the same pulse and hold rules as the IFU response.
REQ-012 SHALL have ports mem_reqValid (out, 1), mem_reqReady (in, 1), mem_wen (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, DATA_W), mem_wmask (out, DATA_W/8): single shared memory request channel.
REQ-013 SHALL have ports mem_respValid (in, 1) and mem_rdata (in, DATA_W): memory response channel.
REQ-014 SHALL have port bus_err, output, 1, one-cycle pulse marking a timed-out transaction.

Function
REQ-015 SHALL implement states IDLE, REQ, WAIT and RESP.
REQ-016 In IDLE, if lsu_reqValid is high, the LSU SHALL be granted, even when ifu_reqValid is also high.
REQ-017 In IDLE, if only ifu_reqValid is high, the IFU SHALL be granted.
REQ-018 A grant SHALL latch owner, address, wen, wdata and wmask into registers and move to REQ on the next edge; IFU grants SHALL latch wen=0 and wmask=0.
REQ-019 In REQ, mem_reqValid SHALL be high and the mem_* fields SHALL be driven from the latched registers, stable until the handshake.
REQ-020 A handshake SHALL be a cycle with mem_reqValid && mem_reqReady; on it, move to WAIT and clear the timeout counter.
REQ-021 In WAIT, mem_respValid SHALL latch mem_rdata into the owner's rdata register and move to RESP.
REQ-022 In WAIT, the timeout counter SHALL increment each cycle without mem_respValid.
REQ-023 When the counter reaches TIMEOUT, the block SHALL latch the owner's rdata as 0xDEADBEEF (truncated or zero-extended to DATA_W), pulse bus_err and move to RESP.
REQ-024 In RESP, exactly the owner's respValid SHALL be high for one cycle, and the next state SHALL be IDLE.
REQ-025 Best-case latency from reqValid in IDLE to respValid SHALL be 3 cycles, reached when mem_reqReady is high and mem_respValid arrives the cycle after the handshake.
REQ-026 mem_respValid outside WAIT SHALL be ignored: no state change and no rdata update.
REQ-027 A requester's reqValid that is still high in the RESP cycle SHALL NOT cause a grant; a grant SHALL be made only from IDLE.
REQ-028 A requester deasserting reqValid after its grant SHALL NOT abort the transaction; the response SHALL still be delivered.
REQ-029 Each respValid SHALL be registered; no combinational path from mem_* inputs to requester outputs is permitted.
REQ-030 Only one transaction SHALL be outstanding at a time.

Reset
REQ-031 Reset SHALL force state=IDLE and clear the counter, owner, mem_reqValid, ifu_respValid, lsu_respValid and bus_err.
REQ-032 Reset SHALL clear ifu_rdata, lsu_rdata, mem_addr, mem_wdata, mem_wmask and mem_wen to 0.
REQ-033 Reset during REQ or WAIT SHALL abandon the transaction.
REQ-034 After a reset abandons a transaction, a late mem_respValid SHALL be ignored under REQ-026, and no respValid SHALL be produced for it.

Structure
REQ-035 State encodings SHALL be defined in the shared defs include, alongside the existing CPU state constants.
REQ-036 Owner encodings (OWNER_IFU, OWNER_LSU) and the error data constant SHALL be defined in the same shared defs include.
REQ-037 The block SHALL be a single module; no sub-module is required.
REQ-038 The CPU state machine's ifu/lsu request and response ports SHALL connect directly to this block's ports.

Verification
REQ-039 Single fetch: ifu_reqValid=1, ifu_addr=0x8000_0000, mem_reqReady=1, mem_rdata=0x0010_0073 one cycle after handshake -> ifu_respValid pulses at cycle 3 with ifu_rdata=0x0010_0073 and lsu_respValid=0.
REQ-040 Simultaneous requests: ifu and lsu reqValid rise together, LSU load at 0x100 -> mem_addr=0x100 first and lsu_respValid first; IFU is granted on the following IDLE.
REQ-041 Backpressure: store wdata=0xA5A5A5A5, wmask=0x3, mem_reqReady low 4 cycles -> mem_* fields stable over those 4 cycles; exactly one handshake; mem_wen=1.
REQ-042 Timeout: TIMEOUT=8, no mem_respValid after handshake -> bus_err and ifu_respValid pulse together after 8 WAIT cycles, with ifu_rdata=0xDEADBEEF.
REQ-043 Reset in WAIT, then mem_respValid=1 two cycles later -> no respValid; state stays IDLE; the next ifu request completes normally.
REQ-044 Spurious mem_respValid in IDLE with rdata=0x1234 -> ifu_rdata and lsu_rdata unchanged; no pulse.
